// File: rtl/mac_pkg.sv
// Shared helpers for the MAC cell family: saturation rails, overflow detect, stage limits.
package mac_pkg;

  localparam int MacMinStages   = 0;
  localparam int MacMaxStages   = 2;
  localparam int MacMaxAccWidth = 64;

  // Largest representable accumulator value, right-aligned in 64 bits.
  function automatic logic [63:0] mac_sat_max(int width, bit is_signed);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < MacMaxAccWidth; i++) begin
      if (i < width - 1 || (!is_signed && i == width - 1)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] mac_sat_min(int width, bit is_signed);
    logic [63:0] r;
    r = '0;
    if (is_signed) r[width-1] = 1'b1;
    return r;
  endfunction

  function automatic logic mac_ovf(bit is_signed, logic acc_msb, logic p_msb, logic sum_msb,
                                   logic carry);
    if (is_signed) return (acc_msb == p_msb) && (sum_msb != acc_msb);
    return carry;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Full-width multiplier followed by a register chain carrying {valid, clr, product}.
module mac_mult_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SIGNED      = 0,
  parameter int unsigned MULT_STAGES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    p_vld,
  output logic                    p_clr,
  output logic [2*DATA_WIDTH-1:0] prod,
  output logic                    busy
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0] a_ext, b_ext, prod_now;

  assign a_ext = (SIGNED != 0) ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
  assign b_ext = (SIGNED != 0) ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
  // Low PW bits of the extended product are exact in both signed and unsigned modes.
  assign prod_now = a_ext * b_ext;

  if (MULT_STAGES == 0) begin : g_comb
    assign p_vld = en;
    assign p_clr = clr;
    assign prod  = prod_now;
    assign busy  = 1'b0;
  end else begin : g_pipe
    logic [MULT_STAGES-1:0] vld_q, clr_q;
    logic [PW-1:0]          prod_q [MULT_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        clr_q <= '0;
        for (int i = 0; i < int'(MULT_STAGES); i++) prod_q[i] <= '0;
      end else begin
        vld_q[0] <= en;
        clr_q[0] <= clr;
        if (en) prod_q[0] <= prod_now;
        for (int i = 1; i < int'(MULT_STAGES); i++) begin
          vld_q[i] <= vld_q[i-1];
          clr_q[i] <= clr_q[i-1];
          if (vld_q[i-1]) prod_q[i] <= prod_q[i-1];
        end
      end
    end

    assign p_vld = vld_q[MULT_STAGES-1];
    assign p_clr = clr_q[MULT_STAGES-1];
    assign prod  = prod_q[MULT_STAGES-1];
    assign busy  = |(vld_q | clr_q);
  end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate cell for a systolic row, with optional saturation and
// a sticky overflow flag; B and en are forwarded to the neighbour one cycle later.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned SIGNED      = 0,
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned MULT_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  ovf,
  output logic                  busy,
  output logic                  en_out,
  output logic [DATA_WIDTH-1:0] b_out
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SatMax =
    ACC_WIDTH'(mac_sat_max(int'(ACC_WIDTH), SIGNED != 0));
  localparam logic [ACC_WIDTH-1:0] SatMin =
    ACC_WIDTH'(mac_sat_min(int'(ACC_WIDTH), SIGNED != 0));

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc_width
    $error("mac_pipe: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end
  if (ACC_WIDTH > MacMaxAccWidth) begin : g_bad_acc_max
    $error("mac_pipe: ACC_WIDTH exceeds 64");
  end
  if (int'(MULT_STAGES) < MacMinStages || int'(MULT_STAGES) > MacMaxStages) begin : g_bad_stages
    $error("mac_pipe: MULT_STAGES must be 0..2");
  end

  logic          p_vld, p_clr;
  logic [PW-1:0] prod;

  mac_mult_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGNED     (SIGNED),
    .MULT_STAGES(MULT_STAGES)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .a    (a_in),
    .b    (b_in),
    .p_vld(p_vld),
    .p_clr(p_clr),
    .prod (prod),
    .busy (busy)
  );

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   p_ext, acc_ext, sum;
  logic                 sum_ovf;

  assign p_ext   = (SIGNED != 0) ? {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod}
                                 : {{(ACC_WIDTH + 1 - PW){1'b0}}, prod};
  assign acc_ext = {(SIGNED != 0) ? acc_q[ACC_WIDTH-1] : 1'b0, acc_q};
  assign sum     = acc_ext + p_ext;
  assign sum_ovf = mac_ovf(SIGNED != 0, acc_q[ACC_WIDTH-1], p_ext[ACC_WIDTH-1],
                           sum[ACC_WIDTH-1], sum[ACC_WIDTH]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (p_clr) begin
      acc_d = p_vld ? p_ext[ACC_WIDTH-1:0] : '0;
      ovf_d = 1'b0;
    end else if (p_vld) begin
      acc_d = sum[ACC_WIDTH-1:0];
      if (sum_ovf) begin
        ovf_d = 1'b1;
        // Signed overflow direction follows the accumulator sign (operands share it).
        if (SATURATE != 0) acc_d = (SIGNED != 0 && acc_q[ACC_WIDTH-1]) ? SatMin : SatMax;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      en_out <= 1'b0;
      b_out  <= '0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      en_out <= en;
      b_out  <= b_in;
    end
  end

  assign c_out = acc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Drives five differently-configured mac_pipe instances with shared stimulus and compares
// each against an integer-arithmetic model of the accumulate rules.
module tb_mac_pipe;

  localparam int NI = 5;
  localparam int unsigned AW_T  [NI] = '{24, 24, 16, 16, 16};
  localparam int unsigned SG_T  [NI] = '{0, 1, 0, 1, 0};
  localparam int unsigned SAT_T [NI] = '{0, 0, 1, 1, 0};
  localparam int unsigned MS_T  [NI] = '{1, 0, 2, 1, 2};

  typedef struct {
    bit         ok;
    bit         en;
    bit         clr;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0;
  logic [7:0] a = '0, b = '0;

  logic [23:0] c_w   [NI];
  logic        ovf_w [NI];
  logic        busy_w[NI];
  logic        eno_w [NI];
  logic [7:0]  bo_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [AW_T[g]-1:0] c;
    mac_pipe #(
      .DATA_WIDTH (8),
      .ACC_WIDTH  (AW_T[g]),
      .SIGNED     (SG_T[g]),
      .SATURATE   (SAT_T[g]),
      .MULT_STAGES(MS_T[g])
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clr   (clr),
      .a_in  (a),
      .b_in  (b),
      .c_out (c),
      .ovf   (ovf_w[g]),
      .busy  (busy_w[g]),
      .en_out(eno_w[g]),
      .b_out (bo_w[g])
    );
    assign c_w[g] = 24'(c);
  end

  // Reference model state
  op_t        hist[4096];
  int         k = 0;
  longint     m_acc[NI];
  bit         m_ovf[NI];
  bit         m_eno;
  logic [7:0] m_bo;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic longint lim_hi(int i);
    return (SG_T[i] != 0) ? (longint'(1) << (AW_T[i] - 1)) - 1 : (longint'(1) << AW_T[i]) - 1;
  endfunction

  function automatic longint lim_lo(int i);
    return (SG_T[i] != 0) ? -(longint'(1) << (AW_T[i] - 1)) : 0;
  endfunction

  function automatic longint prod_of(int i, op_t o);
    if (SG_T[i] != 0) return longint'($signed(o.a)) * longint'($signed(o.b));
    return longint'(o.a) * longint'(o.b);
  endfunction

  function automatic longint wrap(int i, longint s);
    longint r;
    r = s & ((longint'(1) << AW_T[i]) - 1);
    if (SG_T[i] != 0 && r > lim_hi(i)) r = r - (longint'(1) << AW_T[i]);
    return r;
  endfunction

  task automatic model_apply(int i, op_t o);
    longint p, s;
    p = prod_of(i, o);
    if (o.clr) begin
      m_acc[i] = o.en ? p : 0;
      m_ovf[i] = 1'b0;
    end else if (o.en) begin
      s = m_acc[i] + p;
      if (s > lim_hi(i) || s < lim_lo(i)) begin
        m_ovf[i] = 1'b1;
        if (SAT_T[i] != 0) m_acc[i] = (s > lim_hi(i)) ? lim_hi(i) : lim_lo(i);
        else m_acc[i] = wrap(i, s);
      end else begin
        m_acc[i] = s;
      end
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4096; j++) hist[j].ok = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_eno = 1'b0;
    m_bo  = '0;
  endtask

  function automatic bit exp_busy(int i);
    bit r = 1'b0;
    for (int d = 0; d < int'(MS_T[i]); d++) begin
      if (k - d >= 0 && hist[k-d].ok && (hist[k-d].en || hist[k-d].clr)) r = 1'b1;
    end
    return r;
  endfunction

  // Each sampled op reaches the accumulator MULT_STAGES edges after it is sampled.
  always @(posedge clk) begin
    k = k + 1;
    if (rst) begin
      model_reset();
    end else begin
      hist[k] = '{1'b1, en, clr, a, b};
      for (int i = 0; i < NI; i++) begin
        if (k - int'(MS_T[i]) >= 0 && hist[k-int'(MS_T[i])].ok)
          model_apply(i, hist[k-int'(MS_T[i])]);
      end
      m_eno = en;
      m_bo  = b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] mask;
    for (int i = 0; i < NI; i++) begin
      mask = (64'd1 << AW_T[i]) - 64'd1;
      chk($sformatf("d%0d c_out", i), 64'(c_w[i]), 64'(m_acc[i]) & mask);
      chk($sformatf("d%0d ovf", i), 64'(ovf_w[i]), 64'(m_ovf[i]));
      chk($sformatf("d%0d busy", i), 64'(busy_w[i]), 64'(exp_busy(i)));
      chk($sformatf("d%0d en_out", i), 64'(eno_w[i]), 64'(m_eno));
      chk($sformatf("d%0d b_out", i), 64'(bo_w[i]), 64'(m_bo));
    end
  endtask

  task automatic step(input logic s_en, input logic s_clr, input logic [7:0] s_a,
                      input logic [7:0] s_b);
    en  = s_en;
    clr = s_clr;
    a   = s_a;
    b   = s_b;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] corner[4];
    corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(1, 0) == 1) return corner[$urandom_range(3, 0)];
    return 8'($urandom);
  endfunction

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    do_reset();

    // Unsigned 3*4 three times
    repeat (3) step(1'b1, 1'b0, 8'd3, 8'd4);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t1 d0 sum36", 64'(c_w[0]), 64'd36);
    chk("t1 d0 ovf", 64'(ovf_w[0]), 64'd0);

    // Signed -2*5 then +4*5 on the zero-latency signed cell
    step(1'b0, 1'b1, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'hFE, 8'd5);
    chk("t2 d1 neg", 64'(c_w[1]), 64'hFFFFF6);
    step(1'b1, 1'b0, 8'd4, 8'd5);
    chk("t2 d1 pos", 64'(c_w[1]), 64'h00000A);

    // 255*255 twice into 16 bits: saturate vs wrap
    step(1'b0, 1'b1, 8'd0, 8'd0);
    repeat (2) step(1'b1, 1'b0, 8'hFF, 8'hFF);
    repeat (3) step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t3 d2 sat", 64'(c_w[2]), 64'hFFFF);
    chk("t3 d2 ovf", 64'(ovf_w[2]), 64'd1);
    chk("t3 d4 wrap", 64'(c_w[4]), 64'hFC02);
    chk("t3 d4 ovf", 64'(ovf_w[4]), 64'd1);

    // Sum of 50, then clr+en restarts at 6, then clr alone
    step(1'b0, 1'b1, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'd5, 8'd10);
    step(1'b1, 1'b1, 8'd2, 8'd3);
    chk("t4 d0 sum50", 64'(c_w[0]), 64'd50);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t4 d0 restart", 64'(c_w[0]), 64'd6);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t4 d0 cleared", 64'(c_w[0]), 64'd0);
    repeat (3) step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t4 d4 ovf cleared", 64'(ovf_w[4]), 64'd0);

    // Two-stage cell: en then clr, program order preserved
    step(1'b1, 1'b0, 8'd7, 8'd9);
    chk("t5 busy t+1", 64'(busy_w[2]), 64'd1);
    step(1'b0, 1'b1, 8'd0, 8'd0);
    chk("t5 busy t+2", 64'(busy_w[2]), 64'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t5 prod t+3", 64'(c_w[2]), 64'd63);
    chk("t5 busy t+3", 64'(busy_w[2]), 64'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t5 clear t+4", 64'(c_w[2]), 64'd0);
    chk("t5 busy t+4", 64'(busy_w[2]), 64'd0);

    // Reset with products in flight
    step(1'b1, 1'b0, 8'd11, 8'd13);
    step(1'b1, 1'b0, 8'd17, 8'd19);
    do_reset();
    chk("t6 d2 c_out", 64'(c_w[2]), 64'd0);
    repeat (4) step(1'b0, 1'b0, 8'd0, 8'd0);
    chk("t6 no stale", 64'(c_w[2]), 64'd0);

    // Randomized traffic with a mid-stream reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0), pick(), pick());
    end
    repeat (4) step(1'b0, 1'b0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
